// File: rtl/tens_minute_counter_if.sv
// tens_minute_counter_if: control/status bundle between the tens-minute digit and its environment
//   bin         borrow level from the ones digit
//   ones_count  current ones-minute BCD digit
//   SW          SW[4:1] mode select, SW[5] cancel, SW[0] unused
//   BTNU, BTND  start requests
//   count       tens-minute BCD digit
//   running     high while counting down
//   done        high once the cycle has finished
//   err         sticky borrow-at-zero flag
interface tens_minute_counter_if;
    logic       bin;
    logic [3:0] ones_count;
    logic [5:0] SW;
    logic       BTNU;
    logic       BTND;
    logic [3:0] count;
    logic       running;
    logic       done;
    logic       err;
    modport master (output bin, ones_count, SW, BTNU, BTND, input count, running, done, err);
    modport slave (input bin, ones_count, SW, BTNU, BTND, output count, running, done, err);
endinterface

// File: rtl/tens_minute_counter.sv
// tens_minute_counter: tens-of-minutes countdown digit with per-mode load, end-of-cycle detect and borrow-at-zero error
//   CLK100MHZ  system clock, rising edge
//   RST        asynchronous active-high reset
//   bus        tens_minute_counter_if.slave (borrow/ones/switch/button inputs, count/running/done/err outputs)
module tens_minute_counter #(
    parameter logic [3:0] TENS_DELICATE = 4'd1,
    parameter logic [3:0] TENS_NORMAL   = 4'd3,
    parameter logic [3:0] TENS_POWER    = 4'd4,
    parameter logic [3:0] TENS_DRYER    = 4'd6
) (
    input  logic                  CLK100MHZ,
    input  logic                  RST,
    tens_minute_counter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       err_q, err_d;
    logic       old_bin_q;
    logic       bedge, start, cancel, at_end;
    logic [3:0] mode_val;
    logic       unused_sw0;
    assign unused_sw0 = bus.SW[0];
    always_comb begin
        bedge    = bus.bin & ~old_bin_q;
        cancel   = bus.SW[5];
        start    = (bus.BTNU | bus.BTND) & (|bus.SW[4:1]) & ~cancel;
        mode_val = bus.SW[4] ? TENS_DRYER : bus.SW[3] ? TENS_POWER : bus.SW[2] ? TENS_NORMAL : TENS_DELICATE;
        at_end   = (count_q == 4'd0) && (bus.ones_count == 4'd0);
        state_d  = state_q;
        count_d  = count_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                count_d = start ? mode_val : 4'd0;
                state_d = start ? RUN : IDLE;
            end
            RUN: begin
                // Cancel beats end detect, which beats any borrow in the same cycle.
                if (cancel) begin
                    count_d = 4'd0;
                    state_d = IDLE;
                end else if (at_end) begin
                    state_d = DONE;
                end else if (bedge && count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else if (bedge) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                count_d = 4'd0;
                state_d = (bus.SW[4:1] == 4'd0 || cancel) ? IDLE : DONE;
            end
            default: begin
                count_d = 4'd0;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            err_q     <= 1'b0;
            old_bin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            err_q     <= err_d;
            old_bin_q <= bus.bin;
        end
    end
    assign bus.count   = count_q;
    assign bus.running = state_q == RUN;
    assign bus.done    = state_q == DONE;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_tens_minute_counter.sv
// tb_tens_minute_counter: directed stimulus with a per-cycle behavioural model comparison plus literal spot checks
module tb_tens_minute_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    tens_minute_counter_if bus ();
    tens_minute_counter dut (.CLK100MHZ(clk), .RST(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    int m_phase, m_count, m_err, m_prev_bin;
    bit rise;
    function automatic int load_of(logic [5:0] sw);
        int tbl [5] = '{0, 1, 3, 4, 6};
        for (int i = 4; i >= 1; i--) if (sw[i]) return tbl[i];
        return 0;
    endfunction
    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_count = 0; m_err = 0; m_prev_bin = 0;
        end else begin
            rise = bus.bin && !m_prev_bin;
            m_prev_bin = bus.bin;
            case (m_phase)
                0: if ((bus.BTNU || bus.BTND) && bus.SW[4:1] != 0 && !bus.SW[5]) begin
                    m_count = load_of(bus.SW);
                    m_phase = 1;
                end
                1: if (bus.SW[5]) begin
                    m_count = 0; m_phase = 0;
                end else if (m_count == 0 && bus.ones_count == 0) begin
                    m_phase = 2;
                end else if (rise) begin
                    if (m_count > 0) m_count--;
                    else begin m_err = 1; m_phase = 2; end
                end
                default: if (bus.SW[4:1] == 0 || bus.SW[5]) m_phase = 0;
            endcase
        end
    end
    always @(posedge clk) begin
        #1;
        chk("model_count", int'(bus.count), m_count);
        chk("model_running", int'(bus.running), int'(m_phase == 1));
        chk("model_done", int'(bus.done), int'(m_phase == 2));
        chk("model_err", int'(bus.err), m_err);
    end
    task automatic step(int n = 1);
        repeat (n) @(negedge clk);
    endtask
    task automatic bpulse(int n);
        repeat (n) begin
            bus.bin = 1'b1; step();
            bus.bin = 1'b0; step();
        end
    endtask
    task automatic start(logic [5:0] sw, bit use_u);
        bus.SW = sw;
        if (use_u) bus.BTNU = 1'b1; else bus.BTND = 1'b1;
        step();
        bus.BTNU = 1'b0; bus.BTND = 1'b0;
    endtask
    initial begin
        bus.bin = 1'b0; bus.ones_count = 4'd5; bus.SW = 6'd0; bus.BTNU = 1'b0; bus.BTND = 1'b0;
        step(2);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_running", int'(bus.running), 0);
        rst = 1'b0;
        step();
        start(6'b000100, 1'b1);
        chk("normal_load", int'(bus.count), 3);
        chk("normal_running", int'(bus.running), 1);
        bpulse(1); chk("dec_2", int'(bus.count), 2);
        bpulse(1); chk("dec_1", int'(bus.count), 1);
        bpulse(1); chk("dec_0", int'(bus.count), 0);
        chk("no_done_ones5", int'(bus.done), 0);
        bus.ones_count = 4'd0; step();
        chk("end_done", int'(bus.done), 1);
        chk("end_running", int'(bus.running), 0);
        bus.SW = 6'd0; step();
        chk("done_to_idle", int'(bus.done), 0);
        bus.ones_count = 4'd5;
        start(6'b011010, 1'b0);
        chk("prio_sw4", int'(bus.count), 6);
        bpulse(4);
        chk("dec_to_2", int'(bus.count), 2);
        bus.SW = 6'b100000; step();
        chk("cancel_count", int'(bus.count), 0);
        chk("cancel_running", int'(bus.running), 0);
        bus.SW = 6'd0;
        bpulse(2);
        chk("idle_bin_count", int'(bus.count), 0);
        chk("idle_bin_err", int'(bus.err), 0);
        start(6'b000010, 1'b1);
        chk("delicate_load", int'(bus.count), 1);
        bpulse(1);
        chk("delicate_0", int'(bus.count), 0);
        bpulse(1);
        chk("borrow0_err", int'(bus.err), 1);
        chk("borrow0_done", int'(bus.done), 1);
        bus.SW = 6'd0; step();
        chk("err_sticky", int'(bus.err), 1);
        start(6'b000100, 1'b1);
        bus.SW = 6'b010000; bus.BTNU = 1'b1; step();
        bus.BTNU = 1'b0;
        chk("no_reload", int'(bus.count), 3);
        bus.bin = 1'b1; step(10);
        bus.bin = 1'b0; step();
        chk("held_bin_once", int'(bus.count), 2);
        #2 rst = 1'b1;
        #1;
        chk("async_count", int'(bus.count), 0);
        chk("async_running", int'(bus.running), 0);
        chk("async_done", int'(bus.done), 0);
        chk("async_err", int'(bus.err), 0);
        step();
        rst = 1'b0;
        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
